// File: rtl/mine_placer_pkg.sv
// Shared definitions for the mine placer: grid limits, LFSR taps, FSM states
// and the target-count clamp used when a new level is latched.
package mine_placer_pkg;

  localparam int          GRID_MAX  = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PLACE,
    ST_DONE
  } placer_state_e;

  typedef logic [3:0] coord_t;

  // One cell must always stay free, so the count is capped at n*n-1.
  function automatic logic [5:0] clamp_target(input logic [5:0] mines,
                                              input logic [4:0] n,
                                              input logic [4:0] n_max);
    logic [8:0] sq;
    logic [8:0] lim;
    sq  = {4'd0, n} * {4'd0, n};
    lim = sq - 9'd1;
    if (n == 5'd0 || n > n_max) return 6'd0;
    if ({3'd0, mines} < lim) return mines;
    return lim[5:0];
  endfunction

endpackage

// File: rtl/mine_placer_if.sv
// Level request, status and map read port of the mine placer.
interface mine_placer_if;
  import mine_placer_pkg::*;

  logic       start;
  logic [5:0] mines_in;
  logic [4:0] button_num;
  coord_t     rd_x;
  coord_t     rd_y;
  logic       rd_mine;
  logic       busy;
  logic       mines_ready;
  logic [5:0] placed;

  modport master (
    output start, mines_in, button_num, rd_x, rd_y,
    input  rd_mine, busy, mines_ready, placed
  );

  modport slave (
    input  start, mines_in, button_num, rd_x, rd_y,
    output rd_mine, busy, mines_ready, placed
  );

endinterface

// File: rtl/mine_placer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; shifts left, feedback is the XOR of the tapped bits.
module lfsr16 #(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter logic [15:0] TAPS  = 16'hB400,
  parameter int          OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OUT_W-1:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  assign state_d = {state_q[14:0], ^(state_q & TAPS)};
  assign state_o = state_q[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

endmodule

// File: rtl/mine_placer.sv
// Scatters the requested number of mines over an n x n grid at distinct
// pseudo-random cells and serves the resulting map through a registered read port.
module mine_placer
  import mine_placer_pkg::*;
#(
  parameter int          MAX_GRID  = GRID_MAX,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  mine_placer_if.slave bus
);

  localparam logic [4:0] N_MAX = 5'(MAX_GRID);

  placer_state_e                     state_q;
  logic [MAX_GRID-1:0][MAX_GRID-1:0] map_q;
  logic [4:0]                        n_q;
  logic [4:0]                        n_d;
  logic [5:0]                        target_q;
  logic [5:0]                        target_d;
  logic [5:0]                        placed_q;
  logic [5:0]                        placed_d;
  logic                              busy_q;
  logic                              ready_q;
  logic                              rd_mine_q;
  logic [7:0]                        lfsr;
  coord_t                            cx;
  coord_t                            cy;
  logic                              accept;

  // The generator keeps running in every state so the moment of start adds entropy.
  lfsr16 #(
    .SEED  (LFSR_SEED),
    .TAPS  (LFSR_TAPS),
    .OUT_W (8)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .state_o (lfsr)
  );

  assign cx       = lfsr[3:0];
  assign cy       = lfsr[7:4];
  assign placed_d = placed_q + 6'd1;
  assign accept   = ({1'b0, cx} < n_q) && ({1'b0, cy} < n_q) && !map_q[cy][cx];

  // Invalid dimensions collapse to an empty request so the FSM drops straight to DONE.
  assign n_d      = (bus.button_num == 5'd0 || bus.button_num > N_MAX) ? 5'd0 : bus.button_num;
  assign target_d = clamp_target(bus.mines_in, bus.button_num, N_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      map_q     <= '0;
      n_q       <= '0;
      target_q  <= '0;
      placed_q  <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      rd_mine_q <= 1'b0;
    end else begin
      rd_mine_q <= map_q[bus.rd_y][bus.rd_x];
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            n_q      <= n_d;
            target_q <= target_d;
            placed_q <= '0;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
            state_q  <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          map_q <= '0;
          if (target_q == 6'd0) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_PLACE;
          end
        end
        ST_PLACE: begin
          if (accept) begin
            map_q[cy][cx] <= 1'b1;
            placed_q      <= placed_d;
            if (placed_d == target_q) begin
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_mine     = rd_mine_q;
  assign bus.busy        = busy_q;
  assign bus.mines_ready = ready_q;
  assign bus.placed      = placed_q;

endmodule

// File: tb/tb_mine_placer.sv
// Scoreboarded bench for mine_placer: directed level requests, a cycle model of
// the LFSR for expected maps, and a monitor that checks every completion.
module tb_mine_placer;

  typedef struct {
    logic [5:0] placed;
    int         doneCnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mine_placer_if bus ();

  mine_placer #(
    .MAX_GRID  (16),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           cycCnt = 0;
  logic [15:0]  mdl;
  logic [255:0] expMap;
  logic [255:0] firstMap;
  exp_t         expQ[$];
  logic         prevReady = 1'b0;

  function automatic logic [15:0] nxt(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always @(posedge clk) begin
    cycCnt <= cycCnt + 1;
    mdl    <= rst ? 16'hACE1 : nxt(mdl);
  end

  task automatic checkOutput(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Replays the placement from the LFSR value seen in the start cycle.
  task automatic computeExpected(input logic [15:0] l0, input logic [4:0] n, input logic [5:0] tgt,
                                 output logic [255:0] m, output int lat);
    logic [15:0] l;
    logic [3:0]  x;
    logic [3:0]  y;
    int          cnt;
    l   = nxt(nxt(l0));
    m   = '0;
    cnt = 0;
    lat = 1;
    while (cnt < int'(tgt) && lat < 70000) begin
      x = l[3:0];
      y = l[7:4];
      if ({1'b0, x} < n && {1'b0, y} < n && !m[int'(y) * 16 + int'(x)]) begin
        m[int'(y) * 16 + int'(x)] = 1'b1;
        cnt++;
      end
      lat++;
      l = nxt(l);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] mines, input logic [4:0] num,
                               input logic [5:0] handTgt, input bit expectDone);
    int   lat;
    exp_t e;
    @(negedge clk);
    bus.mines_in   = mines;
    bus.button_num = num;
    bus.start      = 1'b1;
    if (expectDone) begin
      computeExpected(mdl, num, handTgt, expMap, lat);
      e.placed  = handTgt;
      e.doneCnt = cycCnt + 1 + lat;
      expQ.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("busy_after_start", bus.busy, 1'b1);
    checkOutput("ready_after_start", bus.mines_ready, 1'b0);
  endtask

  task automatic waitDone(input string tag);
    int i;
    i = 0;
    while (!bus.mines_ready && i < 20000) begin
      @(negedge clk);
      i++;
    end
    checkOutput({tag, "_done_timeout"}, bus.mines_ready, 1'b1);
  endtask

  task automatic readMap(output logic [255:0] got);
    got        = '0;
    bus.rd_x   = 4'd0;
    bus.rd_y   = 4'd0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      got[i] = bus.rd_mine;
      if (i < 255) begin
        bus.rd_x = 4'((i + 1) % 16);
        bus.rd_y = 4'((i + 1) / 16);
      end
    end
  endtask

  task automatic checkMap(input string tag, input int n, input int tgt);
    logic [255:0] got;
    int           pop;
    int           outside;
    checkOutput({tag, "_placed"}, bus.placed, tgt);
    checkOutput({tag, "_busy"}, bus.busy, 1'b0);
    readMap(got);
    checkOutput({tag, "_map"}, got, expMap);
    pop     = 0;
    outside = 0;
    for (int i = 0; i < 256; i++) begin
      if (got[i]) begin
        pop++;
        if (i % 16 >= n || i / 16 >= n) outside++;
      end
    end
    checkOutput({tag, "_popcount"}, pop, tgt);
    checkOutput({tag, "_outside"}, outside, 0);
  endtask

  // Every rising mines_ready must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus.mines_ready && !prevReady) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got placed %0d, want no completion", bus.placed);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("done_placed", bus.placed, e.placed);
        checkOutput("done_cycle", cycCnt, e.doneCnt);
      end
    end
    prevReady = bus.mines_ready;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] got;
    int           i;
    int           p;
    bus.start      = 1'b0;
    bus.mines_in   = '0;
    bus.button_num = '0;
    bus.rd_x       = '0;
    bus.rd_y       = '0;
    rst            = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("reset_busy", bus.busy, 1'b0);
    checkOutput("reset_ready", bus.mines_ready, 1'b0);
    checkOutput("reset_placed", bus.placed, 6'd0);
    readMap(got);
    checkOutput("reset_map", got, '0);

    applyStimulus(6'd8, 5'd8, 6'd8, 1'b1);
    waitDone("t2");
    checkMap("t2", 8, 8);

    applyStimulus(6'd50, 5'd16, 6'd50, 1'b1);
    waitDone("t3a");
    checkMap("t3a", 16, 50);
    firstMap = expMap;
    repeat (7) @(negedge clk);
    applyStimulus(6'd50, 5'd16, 6'd50, 1'b1);
    waitDone("t3b");
    checkMap("t3b", 16, 50);
    readMap(got);
    checkOutput("t3_pattern_differs", (got != firstMap), 1'b1);

    applyStimulus(6'd20, 5'd4, 6'd15, 1'b1);
    waitDone("t4");
    checkMap("t4", 4, 15);

    applyStimulus(6'd5, 5'd0, 6'd0, 1'b1);
    @(negedge clk);
    checkOutput("t5_n0_two_cycles", {bus.busy, bus.mines_ready}, 2'b01);
    checkMap("t5_n0", 0, 0);
    applyStimulus(6'd5, 5'd17, 6'd0, 1'b1);
    @(negedge clk);
    checkOutput("t5_n17_two_cycles", {bus.busy, bus.mines_ready}, 2'b01);
    checkMap("t5_n17", 0, 0);
    applyStimulus(6'd0, 5'd10, 6'd0, 1'b1);
    @(negedge clk);
    checkOutput("t5_m0_two_cycles", {bus.busy, bus.mines_ready}, 2'b01);
    checkMap("t5_m0", 10, 0);

    applyStimulus(6'd50, 5'd16, 6'd50, 1'b1);
    i = 0;
    while (bus.placed < 6'd3 && i < 20000) begin
      @(negedge clk);
      i++;
    end
    checkOutput("t6_reach3", (bus.placed >= 6'd3), 1'b1);
    p              = int'(bus.placed);
    bus.mines_in   = 6'd1;
    bus.button_num = 5'd2;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("t6_start_ignored", (int'(bus.placed) >= p) && bus.busy, 1'b1);
    waitDone("t6a");
    checkMap("t6a", 16, 50);

    applyStimulus(6'd50, 5'd16, 6'd50, 1'b0);
    i = 0;
    while (bus.placed != 6'd5 && i < 20000) begin
      @(negedge clk);
      i++;
    end
    checkOutput("t6_reach5", bus.placed, 6'd5);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_outputs", {bus.busy, bus.mines_ready, bus.placed, bus.rd_mine}, '0);
    rst = 1'b0;
    readMap(got);
    checkOutput("t6_rst_map", got, '0);
    checkOutput("t6_rst_placed", bus.placed, 6'd0);

    repeat (4) @(negedge clk);
    checkOutput("queue_empty", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mine_placer.md
Name: mine_placer

Overview:
- Sits directly downstream of the level-selection stage.
- On the one-cycle level_enable pulse it latches the mine count and grid dimension, then scatters that many mines at pseudo-random, distinct cells of an N x N grid (N ≤ 16).
- Holds the resulting mine map for board-drawing and game-logic stages, served through a registered read port.

Parameters:
- MAX_GRID, 16, maximum grid dimension; the map is MAX_GRID x MAX_GRID bits.
- LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR; must be non-zero.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  level_enable pulse from level selection; sampled only in IDLE and DONE
- mines_in  in  6  requested mine count, valid in the start cycle
- button_num  in  5  grid dimension N, valid in the start cycle
- rd_x  in  4  read column
- rd_y  in  4  read row
- rd_mine  out  1  mine bit at (rd_x, rd_y), one-cycle latency
- busy  out  1  high while clearing or placing
- mines_ready  out  1  high from placement completion until next start or rst
- placed  out  6  number of mines placed so far

Behaviour:
- Reset values: all outputs 0; map cleared; LFSR = LFSR_SEED; state IDLE.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11 (maximal length).
  - Advances every clk cycle outside reset, in all states, so start timing adds entropy.
  - Candidate cell: cx = lfsr[3:0], cy = lfsr[7:4].
- States: IDLE, CLEAR, PLACE, DONE.
- IDLE, or DONE, when start=1:
  - Latch n = button_num.
  - Latch target = min(mines_in, n*n - 1); product is computed at 9 bits.
  - If n == 0 or n > MAX_GRID: target = 0 and n = 0.
  - Next state CLEAR; busy=1; mines_ready=0; placed=0.
- CLEAR (1 cycle):
  - Clear the whole map.
  - Next state DONE if target == 0, else PLACE.
- PLACE: each cycle, the candidate is accepted if all of these hold:
  - cx < n
  - cy < n
  - map[cy][cx] == 0
- On accept, in the same edge:
  - Set the map bit.
  - placed += 1.
  - If placed+1 == target: next state DONE, busy=0, mines_ready=1.
- On reject: no change; retry next cycle.
- Rate and termination: at most one mine per cycle. Termination is guaranteed because the low LFSR byte covers all 256 values within each 65535-cycle period.
- start is ignored while in CLEAR or PLACE.
- DONE: map, placed and mines_ready are held. A new start restarts via CLEAR.
- Read port: rd_mine <= map[rd_y][rd_x] on every edge, in any state. Addresses ≥ n return the stored 0.
- Reset mid-operation returns to reset values; the map is cleared on the same edge.
- Invariants:
  - placed never exceeds target.
  - No cell is placed twice.
  - Every mine lies within the n x n region.

Decomposition:
- Shared game package:
  - MAX_GRID constant
  - placer state enum (2 bits)
  - LFSR tap constant
  - grid coordinate typedef (logic [3:0])
- Natural sub-module: lfsr16 (free-running, seeded, parameterised taps). All other logic stays in mine_placer.

Test Plan:
1. rst held 3 cycles → rd_mine=0 for all 256 addresses; busy=0; mines_ready=0; placed=0.
2. start with mines_in=8, button_num=8 → busy=1 next cycle; mines_ready=1 within bounded cycles. Then placed=8, exactly 8 set bits, all with x<8 and y<8. The map matches a cycle-accurate LFSR model with the same start cycle.
3. mines_in=50, button_num=16 → 50 distinct mines. Second start from DONE → map cleared, then 50 new mines; the pattern differs when the start cycle differs.
4. mines_in=20, button_num=4 → target clamped to 15; placed=15; exactly one empty cell in the 4x4 region.
5. Invalid or empty requests:
   - button_num=0 → CLEAR then DONE in 2 cycles, placed=0.
   - button_num=17 → same response.
   - mines_in=0 with button_num=10 → same response.
6. Assert rst while PLACE has placed=5 → next cycle all outputs 0 and map empty. A start pulse during PLACE is ignored (placed is not reset).
